// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: two-requester round-robin arbiter that loads a byte and paces shift strobes for one frame
module serial_tx_scheduler #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FRAME_BITS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] load_data,
  output logic       pload,
  output logic       shift_en,
  output logic       busy,
  output logic       grant_id
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  localparam logic [7:0] BAUD_END = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] BITS_END = 4'(FRAME_BITS - 1);
  state_t state, state_n;
  logic [7:0] baud, baud_n, load_n;
  logic [3:0] bits, bits_n;
  logic last_grant, last_grant_n, grant_n, ack0_n, ack1_n, win;
  always_comb begin
    state_n = state;
    baud_n = baud;
    bits_n = bits;
    last_grant_n = last_grant;
    grant_n = grant_id;
    load_n = load_data;
    ack0_n = 1'b0;
    ack1_n = 1'b0;
    win = (req0 && req1) ? ~last_grant : req1;
    case (state)
      IDLE: if (req0 || req1) begin
        state_n = LOAD;
        last_grant_n = win;
        grant_n = win;
        load_n = win ? data1 : data0;
        ack0_n = ~win;
        ack1_n = win;
      end
      LOAD: begin
        state_n = SHIFT;
        baud_n = 8'd0;
        bits_n = 4'd0;
      end
      SHIFT: if (baud == BAUD_END) begin
        baud_n = 8'd0;
        bits_n = (bits == BITS_END) ? 4'd0 : bits + 4'd1;
        state_n = (bits == BITS_END) ? IDLE : SHIFT;
      end else baud_n = baud + 8'd1;
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      baud <= 8'd0;
      bits <= 4'd0;
      last_grant <= 1'b1;
      grant_id <= 1'b0;
      load_data <= 8'h00;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      pload <= 1'b0;
      shift_en <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bits <= bits_n;
      last_grant <= last_grant_n;
      grant_id <= grant_n;
      load_data <= load_n;
      ack0 <= ack0_n;
      ack1 <= ack1_n;
      pload <= state_n == LOAD;
      shift_en <= state_n == SHIFT && baud_n == BAUD_END;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb_serial_tx_scheduler: directed scenarios plus random traffic against a frame-timeline reference model
module tb_serial_tx_scheduler;
  localparam int CPB = 4;
  localparam int FB = 10;
  logic clk = 0, reset = 1, req0 = 0, req1 = 0;
  logic [7:0] data0 = 0, data1 = 0;
  logic ack0, ack1, pload, shift_en, busy, grant_id;
  logic [7:0] load_data;
  int passed = 0, total = 0;
  bit m_act = 0, m_lg = 1, m_gid = 0, m_a0 = 0, m_a1 = 0, w;
  int m_k = 0;
  logic [7:0] m_ld = 0;
  logic [13:0] got, exp_v;

  serial_tx_scheduler #(.CLKS_PER_BIT(CPB), .FRAME_BITS(FB)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .load_data(load_data), .pload(pload), .shift_en(shift_en),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // model: a frame is k = 0..FB*CPB cycles after pload, shifting whenever k is a nonzero multiple of CPB
  always @(posedge clk) begin
    if (reset) begin
      m_act = 0; m_k = 0; m_lg = 1; m_gid = 0; m_ld = 0; m_a0 = 0; m_a1 = 0;
    end else begin
      m_a0 = 0; m_a1 = 0;
      if (m_act) begin
        if (m_k == FB * CPB) m_act = 0; else m_k++;
      end else if (req0 || req1) begin
        w = (req0 && req1) ? !m_lg : req1;
        m_lg = w; m_gid = w; m_ld = w ? data1 : data0;
        m_a0 = !w; m_a1 = w; m_act = 1; m_k = 0;
      end
    end
    #1;
    exp_v = {m_act && m_k == 0, m_act && m_k > 0 && m_k % CPB == 0, m_act, m_a0, m_a1, m_gid, m_ld};
    got = {pload, shift_en, busy, ack0, ack1, grant_id, load_data};
    total++;
    if (got !== exp_v) $display("FAIL model {pload,shift,busy,ack0,ack1,gid,data}: got %h expected %h at %0t", got, exp_v, $time);
    else passed++;
    total++;
    if ((pload & shift_en) !== 1'b0 || (ack0 & ack1) !== 1'b0)
      $display("FAIL invariant: pload&shift_en=%b ack0&ack1=%b expected 0 at %0t", pload & shift_en, ack0 & ack1, $time);
    else passed++;
  end

  task automatic wait_idle;
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b expected 0 within 60 cycles", busy);
    else passed++;
  endtask

  task automatic test_reset;
    reset = 1; req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({pload, shift_en, busy, ack0, ack1, grant_id, load_data} !== 14'd0)
      $display("FAIL reset_outputs: got %h expected 0", {pload, shift_en, busy, ack0, ack1, grant_id, load_data});
    else passed++;
    reset = 0;
  endtask

  task automatic test_single;
    int shifts = 0;
    req0 = 1; data0 = 8'hA5;
    @(negedge clk);
    req0 = 0;
    total++;
    if ({pload, ack0, ack1, grant_id, load_data} !== {4'b1100, 8'hA5})
      $display("FAIL single_load: got %h expected %h", {pload, ack0, ack1, grant_id, load_data}, {4'b1100, 8'hA5});
    else passed++;
    for (int j = 2; j <= 42; j++) begin
      @(negedge clk);
      shifts += int'(shift_en);
      total++;
      if (shift_en !== (j >= 5 && (j - 1) % 4 == 0) || busy !== (j <= 41))
        $display("FAIL single_timing C+%0d: shift_en=%b busy=%b expected %b %b", j, shift_en, busy, j >= 5 && (j - 1) % 4 == 0, j <= 41);
      else passed++;
    end
    total++;
    if (shifts != FB) $display("FAIL single_shift_count: got %0d expected %0d", shifts, FB);
    else passed++;
  endtask

  task automatic test_round_robin;
    int last = -1, n = 0;
    reset = 1; req0 = 1; req1 = 1; data0 = 8'h11; data1 = 8'h22;
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk);
      if (pload) begin
        total++;
        if (grant_id !== n[0] || load_data !== (n[0] ? 8'h22 : 8'h11))
          $display("FAIL rr_grant %0d: grant=%b data=%h expected %b %h", n, grant_id, load_data, n[0], n[0] ? 8'h22 : 8'h11);
        else passed++;
        if (n > 0) begin
          total++;
          if (c - last != FB * CPB + 2) $display("FAIL rr_spacing: got %0d expected %0d", c - last, FB * CPB + 2);
          else passed++;
        end
        last = c; n++;
      end
    end
    total++;
    if (n != 4) $display("FAIL rr_frames: got %0d expected 4", n);
    else passed++;
    req0 = 0; req1 = 0;
    wait_idle();
  endtask

  task automatic test_late_request;
    int shifts = 0, d = 0;
    req0 = 1; data0 = 8'h3C;
    @(negedge clk);
    req0 = 0;
    for (int i = 0; i < 20 && shifts < 3; i++) begin
      @(negedge clk);
      shifts += int'(shift_en);
    end
    req1 = 1; data1 = 8'hC3;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      d++;
      if (ack1) break;
    end
    total++;
    if (d != 30 || ack1 !== 1'b1 || grant_id !== 1'b1 || load_data !== 8'hC3)
      $display("FAIL late_ack1: after %0d cycles ack1=%b gid=%b data=%h expected 30 1 1 c3", d, ack1, grant_id, load_data);
    else passed++;
    req1 = 0;
    wait_idle();
  endtask

  task automatic test_reset_mid_frame;
    int shifts = 0;
    req0 = 1; data0 = 8'h5A;
    for (int i = 0; i < 30 && shifts < 5; i++) begin
      @(negedge clk);
      shifts += int'(shift_en);
    end
    reset = 1;
    @(negedge clk);
    total++;
    if ({pload, shift_en, busy, ack0, ack1, grant_id, load_data} !== 14'd0)
      $display("FAIL abort_outputs: got %h expected 0", {pload, shift_en, busy, ack0, ack1, grant_id, load_data});
    else passed++;
    reset = 0;
    @(negedge clk);
    total++;
    if (pload !== 1'b1 || ack0 !== 1'b1 || load_data !== 8'h5A)
      $display("FAIL abort_restart: pload=%b ack0=%b data=%h expected 1 1 5a", pload, ack0, load_data);
    else passed++;
    req0 = 0;
    wait_idle();
  endtask

  task automatic test_pulse;
    int a0 = 0, a1 = 0, p = 0, s = 0;
    req0 = 1; data0 = 8'hE7;
    @(negedge clk);
    req0 = 0;
    for (int i = 0; i < 60; i++) begin
      a0 += int'(ack0); a1 += int'(ack1); p += int'(pload); s += int'(shift_en);
      @(negedge clk);
    end
    total++;
    if (a0 != 1 || a1 != 0 || p != 1 || s != FB)
      $display("FAIL pulse_counts: ack0=%0d ack1=%0d pload=%0d shift=%0d expected 1 0 1 %0d", a0, a1, p, s, FB);
    else passed++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset = ($urandom_range(99) == 0);
      if ($urandom_range(5) == 0) req0 = !req0;
      if ($urandom_range(5) == 0) req1 = !req1;
      if (!req0) data0 = 8'($urandom);
      if (!req1) data1 = 8'($urandom);
    end
    reset = 0; req0 = 0; req1 = 0;
    @(negedge clk);
    wait_idle();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_late_request();
    test_reset_mid_frame();
    test_pulse();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
